fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the write port of one synchronous FIFO between NUM_REQ producers, using round-robin arbitration with bounded bursts.
- Drives the FIFO write enable and write data directly, and takes the FIFO full flag as backpressure.
- Sits between the producer blocks and the FIFO write side, in the same clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (at least 2).
- DATA_WIDTH, 4, word width; must equal the FIFO DATA_WIDTH.
- MAX_BURST, 4, maximum words accepted per grant (at least 1).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester write request; bit i belongs to requester i.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot word-accept strobe; gnt[i]=1 means requester i's word is written this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_w_en  out  1  FIFO write enable.
- fifo_w_data  out  DATA_WIDTH  FIFO write data.
- owner  out  $clog2(NUM_REQ)  index of the current grant holder.
- busy  out  1  1 while in state GRANT.

Behaviour:
- Reset: async assert (rst=0) → state IDLE, owner=0, beat_cnt=0, last_owner=NUM_REQ-1.
  - gnt, fifo_w_en, fifo_w_data and busy are 0 immediately; no clock needed.
  - Requester 0 has first priority after reset.
- State IDLE:
  - gnt=0, fifo_w_en=0, fifo_w_data=0, busy=0.
  - If any req bit is set, select the first set bit searching upward from last_owner+1 (mod NUM_REQ).
  - Next edge: owner ← selected index, beat_cnt ← 0, state ← GRANT.
  - Arbitration costs exactly 1 cycle: the first accepted word is at the earliest 1 cycle after req rises.
  - If no req bit is set, stay in IDLE.
- State GRANT:
  - busy=1; fifo_w_data = req_data slice[owner], combinational.
  - accept = req[owner] & ~fifo_full.
  - fifo_w_en = accept; gnt[owner] = accept; all other gnt bits 0.
  - No registered delay from fifo_full to fifo_w_en, so no write is ever issued while full.
  - On accept: beat_cnt ← beat_cnt+1.
- Exit from GRANT to IDLE (last_owner ← owner), on either condition:
  - (a) accept while beat_cnt == MAX_BURST-1, i.e. the burst is complete;
  - (b) req[owner] == 0, i.e. the owner withdrew. No word is written in a cycle where req[owner] is low.
- Full stall: while fifo_full=1 in GRANT:
  - No accept and beat_cnt holds; state stays GRANT.
  - The grant is not revoked for a full FIFO.
- Fairness:
  - A requester holding req continuously through its burst is re-queued behind all other active requesters.
  - A lone requester is re-granted after one IDLE cycle.
  - Maximum sustained throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Requester rules:
  - req_data must be stable while req is high.
  - A word counts as transferred only on a cycle with gnt[i]=1.
  - req may fall at any time, including mid-burst.
  - Requests from non-owners wait; they are never dropped.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - The round-robin search wraps modulo NUM_REQ.
  - MAX_BURST=1 gives single-word grants.
- Reset mid-burst:
  - Abandons the burst; no partial-state retention.
  - Words already accepted remain in the FIFO.

Test Plan:
- Reset values: rst=0 with req=4'b1111 and fifo_full=0 → gnt=0, fifo_w_en=0, fifo_w_data=0, busy=0, owner=0 on every cycle. After release, first grant goes to requester 0.
- Single requester: req=4'b0010 with words A,B,C held over 3 accepts, fifo_full=0 → one IDLE cycle, then gnt=4'b0010 for 3 cycles. FIFO receives A,B,C; req drops → IDLE, last_owner=1.
- All requesting continuously, MAX_BURST=4 → grant order 0,1,2,3,0.
  - Each owner gets exactly 4 consecutive gnt pulses, with 1 idle cycle between owners.
  - 16 words written in 20 cycles.
- Full stall: requester 2 owner, fifo_full=1 for 2 cycles after 2 accepts → gnt=0 and fifo_w_en=0 during the stall; owner and busy hold. After fifo_full drops, 2 more accepts complete the burst of 4.
- Early withdrawal: requester 0 owner, req[0] falls after 2 accepts while req[3]=1 → IDLE next cycle, then owner=3. Requester 0 gets 2 words total.
- Async reset mid-burst: rst asserted between edges during beat 3 → fifo_w_en and gnt go 0 without waiting for a clock edge. After release with req=4'b0100 → owner=2 after 1 cycle and beat_cnt restarts at 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and one FIFO write port.
// master drives requests and the full flag; slave is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_full;
  logic                          fifo_w_en;
  logic [DATA_WIDTH-1:0]         fifo_w_data;
  logic [OW-1:0]                 owner;
  logic                          busy;

  modport master (
    output req, req_data, fifo_full,
    input  gnt, fifo_w_en, fifo_w_data, owner, busy
  );

  modport slave (
    input  req, req_data, fifo_full,
    output gnt, fifo_w_en, fifo_w_data, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port; 1-cycle arbitration, then up to MAX_BURST words.
// fifo_full stalls the current owner combinationally without revoking its grant.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_q, last_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [OW-1:0]         cand;
  logic [OW-1:0]         sel_idx;
  logic                  sel_vld;
  logic                  owner_req;
  logic [DATA_WIDTH-1:0] owner_dat;
  logic                  accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_d          = last_q;
    beat_d          = beat_q;
    cand            = '0;
    sel_idx         = '0;
    sel_vld         = 1'b0;
    owner_req       = 1'b0;
    owner_dat       = '0;
    accept          = 1'b0;
    bus.gnt         = '0;
    bus.fifo_w_en   = 1'b0;
    bus.fifo_w_data = '0;
    bus.busy        = 1'b0;

    // Walk downward so the candidate closest after last_q is the one left in sel_idx.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = OW'((int'(last_q) + k) % NUM_REQ);
      if (bus.req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        owner_req = bus.req[i];
        owner_dat = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          owner_d = sel_idx;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        accept          = owner_req & ~bus.fifo_full;
        bus.busy        = 1'b1;
        bus.fifo_w_en   = accept;
        bus.fifo_w_data = owner_dat;
        for (int i = 0; i < NUM_REQ; i++) begin
          bus.gnt[i] = accept && (owner_q == OW'(i));
        end
        if (!owner_req) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (accept) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.owner = owner_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed stimulus for fifo_wr_arbiter, checked cycle by cycle against a
// behavioural model of the round-robin / bounded-burst rules.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] word [N];
  int m_busy, m_owner, m_cnt, m_last;
  int n_wr;
  int prev_g;
  int ord [$];
  logic [N-1:0] r_prev;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_cnt   = 0;
    m_last  = N - 1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic f);
    bus.req       = r;
    bus.fifo_full = f;
    bus.req_data  = {word[3], word[2], word[1], word[0]};
  endtask

  // One clock cycle: drive, compare on the falling edge, advance model, return just after rising edge.
  task automatic step(input logic [N-1:0] r, input logic f);
    int acc, e_gnt, e_data, a_own;
    drive(r, f);
    acc    = (m_busy != 0 && r[m_owner] && !f) ? 1 : 0;
    e_gnt  = acc ? (1 << m_owner) : 0;
    e_data = m_busy ? int'(word[m_owner]) : 0;
    a_own  = m_owner;
    @(negedge clk);
    check_eq("gnt", int'(bus.gnt), e_gnt);
    check_eq("w_en", int'(bus.fifo_w_en), acc);
    check_eq("w_data", int'(bus.fifo_w_data), e_data);
    check_eq("busy", int'(bus.busy), m_busy);
    check_eq("owner", int'(bus.owner), m_owner);
    if (bus.fifo_w_en) n_wr++;
    if (bus.gnt != 0 && prev_g == 0) ord.push_back(int'(bus.owner));
    prev_g = int'(bus.gnt);

    if (!rst) begin
      model_reset();
    end else if (m_busy == 0) begin
      if (r != 0) begin
        for (int k = 1; k <= N; k++) begin
          if (r[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            break;
          end
        end
        m_busy = 1;
        m_cnt  = 0;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0;
      m_last = m_owner;
    end else if (acc != 0) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end

    @(posedge clk);
    #1;
    if (acc != 0) word[a_own] = DW'($urandom);
  endtask

  initial begin
    for (int i = 0; i < N; i++) word[i] = DW'($urandom);
    model_reset();
    n_wr   = 0;
    prev_g = 0;
    r_prev = '0;

    // Reset held with everyone requesting: nothing may be granted.
    for (int c = 0; c < 3; c++) step(4'b1111, 1'b0);
    rst = 1'b1;

    // All requesting continuously: order 0,1,2,3,0 and 16 words in 20 cycles.
    n_wr = 0;
    ord.delete();
    for (int c = 0; c < 20; c++) step(4'b1111, 1'b0);
    check_eq("wr_in_20", n_wr, 16);
    for (int c = 0; c < 2; c++) step(4'b1111, 1'b0);
    check_eq("order_len", ord.size(), 5);
    for (int k = 0; k < ord.size() && k < 5; k++) check_eq("order", ord[k], k % N);
    step(4'b0000, 1'b0);

    // Lone requester 1: one idle cycle, three words, then withdraw.
    n_wr = 0;
    for (int c = 0; c < 4; c++) step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    check_eq("single_words", n_wr, 3);

    // Requester 2 stalled by a full FIFO after two beats, then completes its burst.
    n_wr = 0;
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    check_eq("stall_words", n_wr, 4);
    step(4'b0000, 1'b0);

    // Requester 0 withdraws after two words while requester 3 waits.
    n_wr = 0;
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b1001, 1'b0);
    check_eq("withdraw_words", n_wr, 2);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    check_eq("owner_after_wd", int'(bus.owner), 3);
    step(4'b0000, 1'b0);

    // Random traffic and backpressure.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) begin
        if (!r_prev[i]) word[i] = DW'($urandom);
        r[i] = ($urandom_range(0, 9) < 6);
      end
      step(r, ($urandom_range(0, 3) == 0));
      r_prev = r;
    end

    // Async reset between edges during the third beat of requester 2.
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    #2;
    check_eq("pre_rst_w_en", int'(bus.fifo_w_en), 1);
    rst = 1'b0;
    #1;
    check_eq("arst_gnt", int'(bus.gnt), 0);
    check_eq("arst_w_en", int'(bus.fifo_w_en), 0);
    check_eq("arst_busy", int'(bus.busy), 0);
    check_eq("arst_owner", int'(bus.owner), 0);
    model_reset();
    @(posedge clk);
    #1;
    step(4'b0100, 1'b0);
    rst = 1'b1;
    n_wr = 0;
    for (int c = 0; c < 6; c++) step(4'b0100, 1'b0);
    check_eq("post_rst_burst", n_wr, 4);
    step(4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
